// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: three read ports and one write port share one memory,
// with round-robin selection and a bounded hold of consecutive grants per requester.
module mem_port_arbiter #(
    parameter int AXI_WIDTH      = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int MAX_HOLD       = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [2:0]                    rd_req_valid,
    output logic [2:0]                    rd_req_ready,
    input  logic [3*AXI_ADDR_WIDTH-1:0]   rd_req_addr,
    output logic [2:0]                    rd_resp_valid,
    output logic [AXI_WIDTH-1:0]          rd_resp_data,
    input  logic                          wr_req_valid,
    output logic                          wr_req_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]     wr_addr,
    input  logic [AXI_WIDTH-1:0]          wr_data,
    input  logic [AXI_WIDTH/8-1:0]        wr_strb,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [AXI_ADDR_WIDTH-1:0]     mem_addr,
    output logic [AXI_WIDTH-1:0]          mem_wdata,
    output logic [AXI_WIDTH/8-1:0]        mem_wstrb,
    input  logic [AXI_WIDTH-1:0]          mem_rdata
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t              state_reg, state_next;
    logic [1:0]          rr_ptr_reg, rr_ptr_next;
    logic [1:0]          owner_reg, owner_next;
    logic [CW-1:0]       hold_cnt_reg, hold_cnt_next;
    logic [CW-1:0]       hold_cnt_inc;
    logic                armed_reg;
    logic [2:0]          resp_valid_reg;

    logic [3:0]          req;
    logic [3:0]          beat;
    logic                arb_en;
    logic                keep;
    logic                grant_any;
    logic [1:0]          grant_id;
    logic [1:0]          scan_base;
    logic [1:0]          cand;
    logic [AXI_ADDR_WIDTH-1:0] rd_addr [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rd_port
            assign rd_addr[gi]      = rd_req_addr[gi*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            assign rd_req_ready[gi] = beat[gi];
        end
    endgenerate

    assign req          = {wr_req_valid, rd_req_valid};
    // No grants during reset nor in the first cycle after it is released.
    assign arb_en       = rstn & armed_reg;
    assign hold_cnt_inc = hold_cnt_reg + CW'(1);

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        owner_next    = owner_reg;
        hold_cnt_next = hold_cnt_reg;
        beat          = '0;
        grant_any     = 1'b0;
        grant_id      = owner_reg;
        cand          = '0;
        keep          = (state_reg == HOLD) && req[owner_reg] && (hold_cnt_reg < HOLD_MAX);
        // A releasing owner re-arbitrates from its successor in the same cycle.
        scan_base     = (state_reg == HOLD) ? owner_reg + 2'd1 : rr_ptr_reg;

        if (keep) begin
            grant_any = 1'b1;
        end else begin
            for (int k = 3; k >= 0; k--) begin
                cand = scan_base + 2'(k);
                if (req[cand]) begin
                    grant_any = 1'b1;
                    grant_id  = cand;
                end
            end
        end

        if ((state_reg == HOLD) && !keep) begin
            state_next    = IDLE;
            rr_ptr_next   = owner_reg + 2'd1;
            hold_cnt_next = '0;
        end

        if (arb_en && grant_any) begin
            beat[grant_id] = 1'b1;
            if (keep) begin
                hold_cnt_next = hold_cnt_inc;
                if (hold_cnt_inc == HOLD_MAX) begin
                    state_next  = IDLE;
                    rr_ptr_next = owner_reg + 2'd1;
                end
            end else begin
                owner_next    = grant_id;
                hold_cnt_next = CW'(1);
                if (MAX_HOLD > 1) begin
                    state_next = HOLD;
                end else begin
                    state_next  = IDLE;
                    rr_ptr_next = grant_id + 2'd1;
                end
            end
        end
    end

    always_comb begin
        mem_addr = wr_addr;
        case (grant_id)
            2'd0:    mem_addr = rd_addr[0];
            2'd1:    mem_addr = rd_addr[1];
            2'd2:    mem_addr = rd_addr[2];
            default: mem_addr = wr_addr;
        endcase
    end

    assign wr_req_ready  = beat[3];
    assign mem_en        = |beat;
    assign mem_we        = beat[3];
    assign mem_wdata     = wr_data;
    assign mem_wstrb     = beat[3] ? wr_strb : '0;
    assign rd_resp_valid = resp_valid_reg & {3{rstn}};
    assign rd_resp_data  = mem_rdata;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            owner_reg      <= '0;
            hold_cnt_reg   <= '0;
            armed_reg      <= 1'b0;
            resp_valid_reg <= '0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            owner_reg      <= owner_next;
            hold_cnt_reg   <= hold_cnt_next;
            armed_reg      <= 1'b1;
            resp_valid_reg <= beat[2:0];
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MAX_HOLD 4 and 1) share stimulus and are
// checked each cycle against a round-robin reference model, plus directed tables.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [2:0]      rd_req_valid = '0;
    logic [3*AW-1:0] rd_req_addr = '0;
    logic            wr_req_valid = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [DW-1:0]   wr_data = '0;
    logic [SW-1:0]   wr_strb = '0;
    logic [DW-1:0]   mem_rdata = '0;

    logic [2:0]      rd_req_ready_o  [2];
    logic [2:0]      rd_resp_valid_o [2];
    logic [DW-1:0]   rd_resp_data_o  [2];
    logic            wr_req_ready_o  [2];
    logic            mem_en_o        [2];
    logic            mem_we_o        [2];
    logic [AW-1:0]   mem_addr_o      [2];
    logic [DW-1:0]   mem_wdata_o     [2];
    logic [SW-1:0]   mem_wstrb_o     [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            mem_port_arbiter #(
                .AXI_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .MAX_HOLD(gi == 0 ? 4 : 1)
            ) dut (
                .clk(clk), .rstn(rstn),
                .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready_o[gi]),
                .rd_req_addr(rd_req_addr),
                .rd_resp_valid(rd_resp_valid_o[gi]), .rd_resp_data(rd_resp_data_o[gi]),
                .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready_o[gi]),
                .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
                .mem_en(mem_en_o[gi]), .mem_we(mem_we_o[gi]), .mem_addr(mem_addr_o[gi]),
                .mem_wdata(mem_wdata_o[gi]), .mem_wstrb(mem_wstrb_o[gi]),
                .mem_rdata(mem_rdata)
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] onehot(input int g);
        if (g < 0) return 4'b0000;
        return 4'b0001 << g;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int g);
        if (g == 3) return wr_addr;
        return rd_req_addr[g*AW +: AW];
    endfunction

    // Reference model: current holder, beats taken so far, and next scan start.
    int         mh [2]       = '{4, 1};
    int         m_holder [2] = '{-1, -1};
    int         m_run [2]    = '{0, 0};
    int         m_ptr [2]    = '{0, 0};
    logic [2:0] m_pend [2]   = '{3'b000, 3'b000};
    bit         m_blocked    = 1'b1;
    bit         m_live       = 1'b0;

    function automatic int model_grant(input int d, input logic [3:0] req);
        int start;
        if (!rstn || m_blocked) return -1;
        if (m_holder[d] >= 0 && req[m_holder[d]]) return m_holder[d];
        start = (m_holder[d] >= 0) ? (m_holder[d] + 1) % 4 : m_ptr[d];
        for (int k = 0; k < 4; k++) begin
            if (req[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : monitor
        logic [3:0] req;
        int g [2];
        req = {wr_req_valid, rd_req_valid};
        for (int d = 0; d < 2; d++) begin
            g[d] = model_grant(d, req);
            if (m_live) begin
                chk($sformatf("ready[%0d]", d), {wr_req_ready_o[d], rd_req_ready_o[d]}, onehot(g[d]));
                chk($sformatf("mem_ctl[%0d]", d), {mem_en_o[d], mem_we_o[d], mem_wstrb_o[d]},
                    {g[d] >= 0, g[d] == 3, (g[d] == 3) ? wr_strb : {SW{1'b0}}});
                if (g[d] >= 0) chk($sformatf("mem_addr[%0d]", d), mem_addr_o[d], addr_of(g[d]));
                if (g[d] == 3) chk($sformatf("mem_wdata[%0d]", d), mem_wdata_o[d], wr_data);
                chk($sformatf("resp_valid[%0d]", d), rd_resp_valid_o[d], rstn ? m_pend[d] : 3'b000);
                if (rstn && m_pend[d] != 3'b000)
                    chk($sformatf("resp_data[%0d]", d), rd_resp_data_o[d], mem_rdata);
            end
        end
        if (!rstn) begin
            for (int d = 0; d < 2; d++) begin
                m_holder[d] = -1;
                m_run[d]    = 0;
                m_ptr[d]    = 0;
                m_pend[d]   = 3'b000;
            end
            m_blocked = 1'b1;
            m_live    = 1'b1;
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_pend[d] = (g[d] >= 0 && g[d] < 3) ? onehot(g[d]) : 3'b000;
                if (m_holder[d] >= 0 && g[d] != m_holder[d]) begin
                    m_ptr[d]    = (m_holder[d] + 1) % 4;
                    m_holder[d] = -1;
                end
                if (g[d] >= 0) begin
                    if (g[d] == m_holder[d]) begin
                        m_run[d]++;
                    end else begin
                        m_holder[d] = g[d];
                        m_run[d]    = 1;
                    end
                    if (m_run[d] == mh[d]) begin
                        m_ptr[d]    = (g[d] + 1) % 4;
                        m_holder[d] = -1;
                    end
                end
            end
            m_blocked = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn         = 1'b0;
        rd_req_valid = '0;
        wr_req_valid = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    typedef struct {
        logic [3:0] valid;
        int         g4;
        int         g1;
    } vec_t;

    vec_t tbl [18];
    logic [DW-1:0] pat_a5;

    initial begin
        tbl[0] = '{4'hF, -1, -1};
        for (int i = 1; i < 18; i++) tbl[i] = '{4'hF, ((i - 1) / 4) % 4, (i - 1) % 4};
        pat_a5 = {16{8'hA5}};

        // All requesters continuously valid from reset
        rd_req_addr = {32'h1020, 32'h1010, 32'h1000};
        wr_addr     = 32'h2000;
        wr_strb     = 16'h0F0F;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            {wr_req_valid, rd_req_valid} = tbl[i].valid;
            @(negedge clk);
            chk($sformatf("tbl%0d_grant_h4", i), {wr_req_ready_o[0], rd_req_ready_o[0]}, onehot(tbl[i].g4));
            chk($sformatf("tbl%0d_grant_h1", i), {wr_req_ready_o[1], rd_req_ready_o[1]}, onehot(tbl[i].g1));
            chk($sformatf("tbl%0d_we_h1", i), mem_we_o[1], tbl[i].g1 == 3);
            if (tbl[i].g4 >= 0)
                chk($sformatf("tbl%0d_addr_h4", i), mem_addr_o[0], addr_of(tbl[i].g4));
            step();
        end

        // Single read on port 1
        do_reset();
        step();
        rd_req_addr  = {32'h1020, 32'h40, 32'h1000};
        rd_req_valid = 3'b010;
        @(negedge clk);
        chk("rd1_ready", {wr_req_ready_o[0], rd_req_ready_o[0]}, 4'b0010);
        chk("rd1_en", mem_en_o[0], 1'b1);
        chk("rd1_addr", mem_addr_o[0], 32'h40);
        chk("rd1_wstrb", mem_wstrb_o[0], 16'h0);
        step();
        rd_req_valid = 3'b000;
        mem_rdata    = pat_a5;
        @(negedge clk);
        chk("rd1_resp_valid", rd_resp_valid_o[0], 3'b010);
        chk("rd1_resp_data", rd_resp_data_o[0], pat_a5);
        chk("rd1_idle_en", mem_en_o[0], 1'b0);
        step();
        @(negedge clk);
        chk("rd1_resp_once", rd_resp_valid_o[0], 3'b000);

        // Write beat with partial strobes
        wr_addr      = 32'h100;
        wr_strb      = 16'h00FF;
        wr_data      = {4{32'hCAFE_F00D}};
        wr_req_valid = 1'b1;
        @(negedge clk);
        chk("wr_we", mem_we_o[0], 1'b1);
        chk("wr_wstrb", mem_wstrb_o[0], 16'h00FF);
        chk("wr_addr", mem_addr_o[0], 32'h100);
        chk("wr_ready", wr_req_ready_o[0], 1'b1);
        step();
        wr_req_valid = 1'b0;
        @(negedge clk);
        chk("wr_no_resp_h4", rd_resp_valid_o[0], 3'b000);
        chk("wr_no_resp_h1", rd_resp_valid_o[1], 3'b000);
        step();

        // Port 0 holds two beats then drops while port 2 waits
        do_reset();
        step();
        rd_req_valid = 3'b101;
        @(negedge clk);
        chk("hold_b1", {wr_req_ready_o[0], rd_req_ready_o[0]}, 4'b0001);
        step();
        @(negedge clk);
        chk("hold_b2", {wr_req_ready_o[0], rd_req_ready_o[0]}, 4'b0001);
        step();
        rd_req_valid = 3'b100;
        @(negedge clk);
        chk("hold_release_p2", {wr_req_ready_o[0], rd_req_ready_o[0]}, 4'b0100);
        step();

        // Reset mid-hold with a read response in flight
        do_reset();
        rd_req_valid = 3'b111;
        wr_req_valid = 1'b1;
        @(negedge clk);
        chk("post_rst_blocked", {wr_req_ready_o[0], rd_req_ready_o[0]}, 4'b0000);
        chk("post_rst_en", mem_en_o[0], 1'b0);
        step();
        step();
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {wr_req_ready_o[0], rd_req_ready_o[0]}, 4'b0000);
        chk("midrst_resp", rd_resp_valid_o[0], 3'b000);
        step();
        rstn = 1'b1;
        @(negedge clk);
        chk("midrst_rel_ready", {wr_req_ready_o[1], rd_req_ready_o[1]}, 4'b0000);
        chk("midrst_rel_resp", rd_resp_valid_o[0], 3'b000);
        step();
        @(negedge clk);
        chk("midrst_first_h4", {wr_req_ready_o[0], rd_req_ready_o[0]}, 4'b0001);
        chk("midrst_first_h1", {wr_req_ready_o[1], rd_req_ready_o[1]}, 4'b0001);
        step();

        // Randomized traffic with occasional resets; monitor checks every cycle
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rstn = ($urandom_range(0, 199) != 0);
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 3) == 0) rd_req_valid[b] = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 3) == 0) wr_req_valid = $urandom_range(0, 2) != 0;
            rd_req_addr = {$urandom, $urandom, $urandom};
            wr_addr     = $urandom;
            wr_data     = {$urandom, $urandom, $urandom, $urandom};
            wr_strb     = SW'($urandom);
            mem_rdata   = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        rstn         = 1'b1;
        rd_req_valid = '0;
        wr_req_valid = 1'b0;
        step();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AXI_WIDTH, default 128, the memory data width in bits; it SHALL be a multiple of 8.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, the byte-address width.
REQ-003 SHALL have parameter MAX_HOLD, default 4, the maximum consecutive grants to one requester; it SHALL be at least 1.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port rd_req_valid, input, 3 bits: per-port read request, for mm2s ports 0..2.
REQ-007 SHALL have port rd_req_ready, output, 3 bits: per-port read grant.
REQ-008 SHALL have port rd_req_addr, input, 3 x AXI_ADDR_WIDTH bits: per-port read byte address.
REQ-009 SHALL have port rd_resp_valid, output, 3 bits: per-port read data valid.
REQ-010 SHALL have port rd_resp_data, output, AXI_WIDTH bits: read data shared by all ports, qualified by rd_resp_valid.
REQ-011 SHALL have port wr_req_valid / wr_req_ready, input / output, 1 bit each: s2mm write handshake.
REQ-012 SHALL have ports wr_addr, wr_data and wr_strb, inputs, of AXI_ADDR_WIDTH, AXI_WIDTH and AXI_WIDTH/8 bits: write address, data and byte strobes.
REQ-013 SHALL have ports mem_en and mem_we, outputs, 1 bit each: single-port memory enable and write enable.
REQ-014 SHALL have ports mem_addr, mem_wdata and mem_wstrb, outputs, of AXI_ADDR_WIDTH, AXI_WIDTH and AXI_WIDTH/8 bits: memory address, write data and strobes.
REQ-015 SHALL have port mem_rdata, input, AXI_WIDTH bits: memory read data, valid exactly 1 cycle after the read beat.

Function
REQ-016 SHALL arbitrate 4 requesters: ids 0..2 are the reads, id 3 is the write; at most one grant per cycle.
REQ-017 SHALL grant combinationally in the request cycle; a beat occurs when a valid and its ready are both high on a rising edge.
REQ-018 SHALL assert ready only to the granted requester and only while that requester's valid is high.
REQ-019 SHALL assert mem_en = 1 in a beat cycle, with mem_addr, mem_we, mem_wdata and mem_wstrb driven from the granted requester.
REQ-020 SHALL set mem_we = 1 only for id 3 and SHALL drive mem_wstrb = 0 on read beats.
REQ-021 SHALL drive mem_en = 0, mem_we = 0 and mem_wstrb = 0 in cycles with no beat; mem_addr and mem_wdata are don't-care then.
REQ-022 SHALL use two states, IDLE and HOLD, for the arbiter FSM.
REQ-023 In IDLE, SHALL pick the first valid requester scanning round-robin from rr_ptr, with wrap 3->0; if it gets a beat, SHALL set owner = id and hold_cnt = 1, and go to HOLD if MAX_HOLD > 1.
REQ-024 In HOLD, SHALL grant the owner exclusively while owner valid is high and hold_cnt < MAX_HOLD, with hold_cnt incrementing per beat.
REQ-025 SHALL release HOLD to IDLE when the owner deasserts valid or hold_cnt reaches MAX_HOLD after a beat.
REQ-026 On release, SHALL set rr_ptr = (owner+1) mod 4, and re-arbitrate in that same cycle so no idle cycle occurs when others are pending.
REQ-027 SHALL keep hold_cnt in a counter of width clog2(MAX_HOLD+1); it SHALL never exceed MAX_HOLD.
REQ-028 With MAX_HOLD = 1, SHALL rotate every beat, and no requester SHALL wait more than 3 beats while its valid is held.
REQ-029 SHALL register the read-beat port id; one cycle later it SHALL pulse rd_resp_valid[id] for exactly 1 cycle with rd_resp_data = mem_rdata.
REQ-030 Read responses SHALL not be backpressured; requesters SHALL accept them.
REQ-031 Back-to-back read beats SHALL yield back-to-back responses in grant order, with throughput 1 beat per cycle.
REQ-032 A write beat SHALL produce no rd_resp_valid.
REQ-033 When a read response and a write beat occur in the same cycle, both SHALL proceed; there is no hazard handling, and ordering is by beat cycle.
REQ-034 Valid deasserted without a beat SHALL leave no state change except FSM release per REQ-025.

Reset
REQ-035 While rstn = 0 at a rising edge, SHALL hold state = IDLE, rr_ptr = 0, hold_cnt = 0, owner = 0 and the response pipeline cleared.
REQ-036 During reset and in the cycle after reset release, SHALL hold rd_req_ready = 0, wr_req_ready = 0, rd_resp_valid = 0, mem_en = 0, mem_we = 0 and mem_wstrb = 0.
REQ-037 Reset asserted mid-HOLD or with a read response in flight SHALL drop that response and grant nothing on the following cycle.

Verification
REQ-038 Single read: port 1 valid with addr 0x40 and mem_rdata = 0xA5 pattern -> mem_en = 1, mem_addr = 0x40 in cycle t; rd_resp_valid = 3'b010 with data 0xA5 pattern at t+1.
REQ-039 All four requesters continuously valid, MAX_HOLD = 4 -> grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0, with no gap cycles.
REQ-040 MAX_HOLD = 1, all four valid -> grants 0,1,2,3,0,1 and mem_we = 1 only on the id-3 beats.
REQ-041 Write with wr_strb = 0x00FF, addr 0x100 -> mem_we = 1, mem_wstrb = 0x00FF, and no rd_resp_valid on the following cycle.
REQ-042 Port 0 holds for 2 beats then drops valid while port 2 is valid -> port 2 is granted in the very next cycle and rr_ptr = 1.
REQ-043 rstn = 0 asserted during HOLD with a read in flight -> the next cycle has all readies 0 and rd_resp_valid = 0, and the first grant after release goes to id 0.
